// File: rtl/note_bend2dds_if.sv
// rtl/note_bend2dds_if.sv - request/result bundle for note_bend2dds; NOTE2DDS_TRANSPOSE_EN adds in_transpose
interface note_bend2dds_if #(
    parameter int ACC_W  = 32,
    parameter int NOTE_W = 9,
    parameter int FRAC_W = 7,
    parameter int CH_W   = 3
);
    // Request side
    logic              in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch;
    logic [NOTE_W-1:0] in_note;
    logic [FRAC_W-1:0] in_frac;
`ifdef NOTE2DDS_TRANSPOSE_EN
    logic signed [7:0] in_transpose;
`endif

    // Result side
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [ACC_W-1:0]  out_adder;

`ifdef NOTE2DDS_TRANSPOSE_EN
    modport master (
        output in_valid, in_ch, in_note, in_frac, in_transpose,
        input  in_ready, out_valid, out_ch, out_adder
    );

    modport slave (
        input  in_valid, in_ch, in_note, in_frac, in_transpose,
        output in_ready, out_valid, out_ch, out_adder
    );
`else
    modport master (
        output in_valid, in_ch, in_note, in_frac,
        input  in_ready, out_valid, out_ch, out_adder
    );

    modport slave (
        input  in_valid, in_ch, in_note, in_frac,
        output in_ready, out_valid, out_ch, out_adder
    );
`endif
endinterface

// File: rtl/note_bend2dds.sv
// rtl/note_bend2dds.sv - time-multiplexed note+fine-pitch to DDS phase increment; NOTE2DDS_TRANSPOSE_EN enables transpose
module note_bend2dds #(
    parameter int ACC_W   = 32,
    parameter int NOTE_W  = 9,
    parameter int FRAC_W  = 7,
    parameter int CH_W    = 3,
    parameter int TOP_OCT = 42
) (
    input  logic          clk,
    input  logic          rst,
    note_bend2dds_if.slave bus
);
    localparam int PW = ACC_W + FRAC_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIV    = 2'd1,
        S_LOOK   = 2'd2,
        S_INTERP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              w_in_ready;
    logic              w_accept;
    logic [NOTE_W-1:0] w_note_eff;
    logic              w_rem_ge12;

    logic [CH_W-1:0]   r_ch;
    logic [NOTE_W-1:0] r_rem;
    logic [5:0]        r_q;
    logic [FRAC_W-1:0] r_frac;
    logic [ACC_W-1:0]  r_base;
    logic [ACC_W-1:0]  r_next;

    logic              r_out_valid;
    logic [CH_W-1:0]   r_out_ch;
    logic [ACC_W-1:0]  r_out_adder;

    logic [PW-1:0]     w_diff;
    logic [PW-1:0]     w_prod;
    logic [PW-1:0]     w_v;
    logic [6:0]        w_shift;

    // Semitone increments for the top octave; index 11 is the default arm.
    function automatic logic [ACC_W-1:0] f_tbl(input logic [3:0] idx);
        case (idx)
            4'd0:    f_tbl = ACC_W'(32'd368205249);
            4'd1:    f_tbl = ACC_W'(32'd390099873);
            4'd2:    f_tbl = ACC_W'(32'd413296419);
            4'd3:    f_tbl = ACC_W'(32'd437872302);
            4'd4:    f_tbl = ACC_W'(32'd463909545);
            4'd5:    f_tbl = ACC_W'(32'd491495042);
            4'd6:    f_tbl = ACC_W'(32'd520720858);
            4'd7:    f_tbl = ACC_W'(32'd551684531);
            4'd8:    f_tbl = ACC_W'(32'd584489400);
            4'd9:    f_tbl = ACC_W'(32'd619244949);
            4'd10:   f_tbl = ACC_W'(32'd656067170);
            default: f_tbl = ACC_W'(32'd695078954);
        endcase
    endfunction

`ifdef NOTE2DDS_TRANSPOSE_EN
    logic signed [NOTE_W+1:0] w_note_sum;

    assign w_note_sum = $signed({2'b00, bus.in_note})
                      + $signed({{(NOTE_W+2-8){bus.in_transpose[7]}}, bus.in_transpose});

    // Clamp the transposed note into 0..2^NOTE_W-1 using the sign and overflow bits.
    always_comb begin
        w_note_eff = w_note_sum[NOTE_W-1:0];
        if (w_note_sum[NOTE_W+1]) begin
            w_note_eff = '0;
        end else if (w_note_sum[NOTE_W]) begin
            w_note_eff = '1;
        end
    end
`else
    assign w_note_eff = bus.in_note;
`endif

    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_rem_ge12 = (r_rem >= NOTE_W'(12));

    // Interpolate between adjacent semitones; the diff is never negative since the table rises.
    assign w_diff  = PW'(r_next - r_base);
    assign w_prod  = w_diff * PW'(r_frac);
    assign w_v     = PW'(r_base) + (w_prod >> FRAC_W);
    assign w_shift = (int'(r_q) >= TOP_OCT) ? 7'd0 : 7'(TOP_OCT - int'(r_q));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: IDLE -> DIV (q+1 cycles) -> LOOK -> INTERP -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_DIV;
            S_DIV:    if (!w_rem_ge12) w_state_next = S_LOOK;
            S_LOOK:   w_state_next = S_INTERP;
            S_INTERP: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Handshake output: ready only while idle and not held in reset.
    always_comb begin
        w_in_ready = 1'b0;
        if ((r_state == S_IDLE) && !rst) begin
            w_in_ready = 1'b1;
        end
    end

    // Datapath: latch request, divide by 12, fetch semitone pair, emit scaled result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch        <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_frac      <= '0;
            r_base      <= '0;
            r_next      <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_adder <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ch   <= bus.in_ch;
                        r_rem  <= w_note_eff;
                        r_q    <= '0;
                        r_frac <= bus.in_frac;
                    end
                end
                S_DIV: begin
                    if (w_rem_ge12) begin
                        r_rem <= r_rem - NOTE_W'(12);
                        r_q   <= r_q + 6'd1;
                    end
                end
                S_LOOK: begin
                    r_base <= f_tbl(r_rem[3:0]);
                    // Above B the next semitone is C of the following octave: twice C.
                    if (r_rem[3:0] == 4'd11) begin
                        r_next <= f_tbl(4'd0) << 1;
                    end else begin
                        r_next <= f_tbl(r_rem[3:0] + 4'd1);
                    end
                end
                S_INTERP: begin
                    r_out_valid <= 1'b1;
                    r_out_ch    <= r_ch;
                    r_out_adder <= ACC_W'(w_v >> w_shift);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_adder = r_out_adder;

endmodule
